// File: rtl/frame_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// frame_sched_ctrl_if
// Purpose : groups the scheduler's pipeline-facing signals (display timing,
//           clipper, raster unit, frame-buffer muxes) into one bundle.
// Signals : sched_en, vblank_start            - scheduler control / timing
//           clr_/clip_/rast_ start + done      - per-stage pulse handshakes
//           fb_front, busy, frame_tick         - status
//           drop_cnt[DROP_W]                   - saturating overrun counter
//           timeout_err                        - only with FRAME_TIMEOUT_EN
// Modports: master - the scheduler (frame_sched_ctrl)
//           slave  - the surrounding pipeline / environment
// Macro   : FRAME_TIMEOUT_EN adds the timeout_err status bit.
// ---------------------------------------------------------------------------
interface frame_sched_ctrl_if #(
    parameter int DROP_W = 8
);
    logic              sched_en;
    logic              vblank_start;
    logic              clr_start;
    logic              clr_done;
    logic              clip_start;
    logic              clip_done;
    logic              rast_start;
    logic              rast_done;
    logic              fb_front;
    logic              busy;
    logic              frame_tick;
    logic [DROP_W-1:0] drop_cnt;
`ifdef FRAME_TIMEOUT_EN
    logic              timeout_err;
`endif

    modport master (
        input  sched_en, vblank_start, clr_done, clip_done, rast_done,
        output clr_start, clip_start, rast_start, fb_front, busy,
               frame_tick, drop_cnt
`ifdef FRAME_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport slave (
        output sched_en, vblank_start, clr_done, clip_done, rast_done,
        input  clr_start, clip_start, rast_start, fb_front, busy,
               frame_tick, drop_cnt
`ifdef FRAME_TIMEOUT_EN
        , input timeout_err
`endif
    );
endinterface

// File: rtl/frame_sched_ctrl.sv
// ---------------------------------------------------------------------------
// frame_sched_ctrl
// Purpose : per-frame scheduler for the VPU render path. A free-running
//           refresh counter paces frames; each accepted frame runs
//           clear -> clip -> raster, then swaps front/back buffers on the
//           next vertical-blank pulse.
// Ports   : clkin  - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           sif    - frame_sched_ctrl_if.master (handshakes and status)
// Macro   : FRAME_TIMEOUT_EN enables a stage watchdog that aborts a frame
//           after REFRESH_CNT*2 cycles in one stage and sets the sticky
//           timeout_err flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame in flight, waiting for an enabled frame tick
// CLEAR    | back buffer clear running, waiting for clr_done
// CLIP     | clipper pass running, waiting for clip_done
// RAST     | raster pass running, waiting for rast_done
// WAIT_VB  | frame rendered, waiting for vblank_start
// SWAP     | single cycle: flip fb_front, return to IDLE
// ---------------------------------------------------------------------------
module frame_sched_ctrl #(
    parameter int REFRESH_CNT = 1666667,
    parameter int CNT_W       = 21,
    parameter int DROP_W      = 8
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    frame_sched_ctrl_if.master    sif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLIP,
        ST_RAST,
        ST_WAIT_VB,
        ST_SWAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clr_q, clr_d;
    logic              clip_q, clip_d;
    logic              rast_q, rast_d;
    logic              front_q, front_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              tick_w;
    logic              tick_en_w;

`ifdef FRAME_TIMEOUT_EN
    localparam logic [23:0] WD_LAST = 24'(REFRESH_CNT * 2 - 1);
    logic [23:0] wdog_q, wdog_d;
    logic        tmo_q, tmo_d;
    logic        in_stage_w;
`endif

    // Refresh counter free-runs regardless of sched_en.
    assign tick_w    = (cnt_q == CNT_LAST);
    assign tick_en_w = tick_w && sif.sched_en;
    assign cnt_d     = tick_w ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        clip_d  = 1'b0;
        rast_d  = 1'b0;
        front_d = front_q;
        drop_d  = drop_q;

        // Any enabled tick that cannot start a frame is an overrun,
        // including one landing in the SWAP cycle.
        if (tick_en_w && (state_q != ST_IDLE) && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_en_w) begin
                    state_d = ST_CLEAR;
                    clr_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (sif.clr_done) begin
                    state_d = ST_CLIP;
                    clip_d  = 1'b1;
                end
            end
            ST_CLIP: begin
                if (sif.clip_done) begin
                    state_d = ST_RAST;
                    rast_d  = 1'b1;
                end
            end
            ST_RAST: begin
                // vblank_start here is deliberately not remembered.
                if (sif.rast_done) state_d = ST_WAIT_VB;
            end
            ST_WAIT_VB: begin
                if (sif.vblank_start) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                front_d = ~front_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef FRAME_TIMEOUT_EN
        tmo_d      = tmo_q;
        in_stage_w = (state_q == ST_CLEAR) || (state_q == ST_CLIP) ||
                     (state_q == ST_RAST);
        if (in_stage_w && (wdog_q == WD_LAST)) begin
            // Abort without swapping; suppress any start pulse of this cycle.
            state_d = ST_IDLE;
            clip_d  = 1'b0;
            rast_d  = 1'b0;
            tmo_d   = 1'b1;
        end
        if ((state_d != state_q) || !in_stage_w) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            clip_q  <= 1'b0;
            rast_q  <= 1'b0;
            front_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            clip_q  <= clip_d;
            rast_q  <= rast_d;
            front_q <= front_d;
            drop_q  <= drop_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    assign sif.timeout_err = tmo_q;
`endif

    assign sif.clr_start  = clr_q;
    assign sif.clip_start = clip_q;
    assign sif.rast_start = rast_q;
    assign sif.fb_front   = front_q;
    assign sif.busy       = (state_q != ST_IDLE);
    assign sif.frame_tick = tick_w;
    assign sif.drop_cnt   = drop_q;

endmodule

// File: tb/tb_frame_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_sched_ctrl
// Purpose : bench for frame_sched_ctrl with a small refresh period. The
//           expected behaviour comes from a frame-level model: a stage index
//           (0 idle, 1..3 render stages, 4 waiting for vblank, 5 swap) that
//           advances on the matching done pulse, ticks derived from the cycle
//           count since reset, and a saturating drop tally.
// ---------------------------------------------------------------------------
module tb_frame_sched_ctrl;

    localparam int R    = 100;
    localparam int DW   = 2;
    localparam int DMAX = 3;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;

    always #5 clkin = ~clkin;

    frame_sched_ctrl_if #(.DROP_W(DW)) sif ();

    frame_sched_ctrl #(
        .REFRESH_CNT (R),
        .CNT_W       (7),
        .DROP_W      (DW)
    ) dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .sif   (sif)
    );

    int n_pass = 0;
    int n_fail = 0;

    // frame-level model
    int m_cyc, m_phase, m_start, m_front, m_drop;
    // environment
    int lat[3];
    int due[3];
    bit en;
    int vb_period, vb_ofs, vb_prob;
    bit stray_on;
    int stray_clip_at;
    // observation records for directed timing checks
    int first_clr, first_clip, first_rast, front_chg;
    int n_clr, n_clip, n_rast;
    logic prev_front;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic clear_records();
        first_clr = -1; first_clip = -1; first_rast = -1; front_chg = -1;
        n_clr = 0; n_clip = 0; n_rast = 0;
    endtask

    task automatic drive_idle_inputs();
        sif.clr_done     = 1'b0;
        sif.clip_done    = 1'b0;
        sif.rast_done    = 1'b0;
        sif.vblank_start = 1'b0;
        sif.sched_en     = en;
    endtask

    // Leaves the bench at the negedge of cycle 0 after reset release.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle_inputs();
        sif.clip_done = 1'b1;
        @(negedge clkin);
        check("rst_busy",  sif.busy,       1'b0);
        check("rst_clr",   sif.clr_start,  1'b0);
        check("rst_clip",  sif.clip_start, 1'b0);
        check("rst_rast",  sif.rast_start, 1'b0);
        check("rst_front", sif.fb_front,   1'b0);
        check("rst_drop",  sif.drop_cnt,   0);
        check("rst_tick",  sif.frame_tick, 1'b0);
        @(negedge clkin);
        sif.clip_done = 1'b0;
        rst_n = 1'b1;
        m_cyc = 0; m_phase = 0; m_start = 0; m_front = 0; m_drop = 0;
        for (int k = 0; k < 3; k++) due[k] = -1;
        prev_front = 1'b0;
        clear_records();
    endtask

    task automatic cycle();
        bit tick;
        bit vb;
        bit dn[4];
        int r;
        tick = ((m_cyc % R) == R - 1);

        check("clr_start",  sif.clr_start,  (m_start == 1));
        check("clip_start", sif.clip_start, (m_start == 2));
        check("rast_start", sif.rast_start, (m_start == 3));
        check("busy",       sif.busy,       (m_phase != 0));
        check("frame_tick", sif.frame_tick, tick);
        check("fb_front",   sif.fb_front,   m_front);
        check("drop_cnt",   sif.drop_cnt,   m_drop);

        if (sif.clr_start  === 1'b1) begin n_clr++;  if (first_clr  < 0) first_clr  = m_cyc; end
        if (sif.clip_start === 1'b1) begin n_clip++; if (first_clip < 0) first_clip = m_cyc; end
        if (sif.rast_start === 1'b1) begin n_rast++; if (first_rast < 0) first_rast = m_cyc; end
        if (sif.fb_front !== prev_front) front_chg = m_cyc;
        prev_front = sif.fb_front;

        // environment: each stage answers lat[k] cycles after its start
        if (m_start != 0) due[m_start-1] = m_cyc + lat[m_start-1];
        dn[0] = 1'b0;
        for (int k = 0; k < 3; k++) dn[k+1] = (m_cyc == due[k]);
        if (m_cyc == stray_clip_at) dn[2] = 1'b1;
        if (stray_on) begin
            r = $urandom_range(31, 0);
            if (r < 3) dn[r+1] = 1'b1;
        end
        vb = (vb_period > 0) && ((m_cyc % vb_period) == vb_ofs);
        if (vb_prob > 0 && $urandom_range(vb_prob - 1, 0) == 0) vb = 1'b1;

        sif.sched_en     = en;
        sif.clr_done     = dn[1];
        sif.clip_done    = dn[2];
        sif.rast_done    = dn[3];
        sif.vblank_start = vb;

        // model step
        m_start = 0;
        if (tick && en && m_phase != 0 && m_drop < DMAX) m_drop++;
        if (tick && en && m_phase == 0) begin
            m_phase = 1;
            m_start = 1;
        end else if (m_phase >= 1 && m_phase <= 3) begin
            if (dn[m_phase]) begin
                m_phase++;
                if (m_phase <= 3) m_start = m_phase;
            end
        end else if (m_phase == 4) begin
            if (vb) m_phase = 5;
        end else if (m_phase == 5) begin
            m_front = 1 - m_front;
            m_phase = 0;
        end
        m_cyc++;
        @(negedge clkin);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        en = 1'b1;
        lat[0] = 5; lat[1] = 5; lat[2] = 5;
        vb_period = 0; vb_ofs = 0; vb_prob = 0;
        stray_on = 1'b0; stray_clip_at = -1;
        m_cyc = 0;
        drive_idle_inputs();

        // basic frame: vblank at cycle 150
        do_reset();
        vb_period = 1000; vb_ofs = 150;
        run(160);
        check("s1_clr_at",   first_clr,  100);
        check("s1_clip_at",  first_clip, 106);
        check("s1_rast_at",  first_rast, 112);
        check("s1_swap_at",  front_chg,  152);
        check("s1_front",    sif.fb_front, 1'b1);

        // long raster: overruns, then saturation at 3
        do_reset();
        lat[2] = 138;
        vb_period = 300; vb_ofs = 20;
        run(301);
        check("s2_drop2",    sif.drop_cnt, 2);
        check("s2_one_clr",  n_clr, 1);
        run(499);
        check("s2_drop_sat", sif.drop_cnt, 3);
        check("s2_frames",   n_clr, 3);

        // rast_done coincident with vblank: swap waits for next vblank
        do_reset();
        lat[2] = 5;
        vb_period = 23; vb_ofs = 2;
        run(120);
        check("s3_no_swap",  sif.fb_front, 1'b0);
        check("s3_waiting",  sif.busy, 1'b1);
        run(30);
        check("s3_swap_at",  front_chg, 142);

        // sched_en low for five frame periods
        en = 1'b0;
        vb_period = 0;
        clear_records();
        run(500);
        check("s4_no_starts", n_clr + n_clip + n_rast, 0);
        check("s4_drop",      sif.drop_cnt, 0);
        check("s4_front",     sif.fb_front, 1'b1);
        en = 1'b1;
        run(60);
        check("s4_reen_clr",  first_clr, 700);

        // reset while in CLIP, stray clip_done afterwards
        do_reset();
        run(108);
        check("s5_in_clip",   sif.busy, 1'b1);
        stray_clip_at = 1;
        do_reset();
        stray_clip_at = 1;
        run(5);
        check("s5_idle",      sif.busy, 1'b0);
        check("s5_no_clip",   n_clip, 0);
        run(100);
        stray_clip_at = -1;
        check("s5_clr_at",    first_clr, 100);

        // randomized traffic
        stray_on = 1'b1;
        vb_prob = 25;
        for (int seg = 0; seg < 20; seg++) begin
            if (seg == 7 || seg == 14) do_reset();
            for (int k = 0; k < 3; k++) lat[k] = $urandom_range(40, 1);
            en = ($urandom_range(3, 0) != 0);
            run($urandom_range(300, 100));
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sched_ctrl.md
Name: frame_sched_ctrl

Overview:
- Per-frame scheduler for the VPU render path.
- A refresh counter paces frames at the display rate.
- Each frame it sequences three stages in order: back-buffer clear, clipper pass, raster (line generator) pass. It then swaps front/back frame buffers on the next vertical-blank pulse.
- Sits between the display timing block, the clipper, the raster unit and the frame-buffer address muxes in cpu_vpu_top.

Parameters:
- REFRESH_CNT, 1666667, clkin cycles per frame tick (60 Hz at 100 MHz).
- CNT_W, 21, width of the refresh counter; must hold REFRESH_CNT.
- DROP_W, 8, width of the dropped-frame counter.

Ports:
- clkin, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sched_en, input, 1, enables frame ticks to start new frames.
- vblank_start, input, 1, one-cycle pulse at the start of vertical blank, from display timing.
- clr_start, output, 1, one-cycle pulse: clear the back buffer.
- clr_done, input, 1, one-cycle pulse: clear finished.
- clip_start, output, 1, one-cycle pulse: run the clipper.
- clip_done, input, 1, one-cycle pulse: clipper finished.
- rast_start, output, 1, one-cycle pulse: run the raster/line generator.
- rast_done, input, 1, one-cycle pulse: raster finished.
- fb_front, output, 1, buffer index scanned out; the back buffer is ~fb_front.
- busy, output, 1, high whenever the state is not IDLE.
- frame_tick, output, 1, one-cycle pulse when the refresh counter wraps.
- drop_cnt, output, DROP_W, saturating count of ticks lost because a frame was still in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE; refresh counter=0; fb_front=0; all start pulses 0; busy=0; frame_tick=0; drop_cnt=0.
- Refresh counter:
  - Free-runs 0..REFRESH_CNT-1, independent of sched_en.
  - When the count equals REFRESH_CNT-1 it returns to 0 and frame_tick is asserted for that one cycle.
- FSM states: IDLE, CLEAR, CLIP, RAST, WAIT_VB, SWAP.
- IDLE: on frame_tick with sched_en=1 -> CLEAR, with clr_start pulsed in the same cycle as the transition (registered; visible the cycle after the tick).
- CLEAR: on clr_done -> CLIP, pulse clip_start.
- CLIP: on clip_done -> RAST, pulse rast_start.
- RAST: on rast_done -> WAIT_VB.
- WAIT_VB: on vblank_start -> SWAP.
  - A vblank_start coincident with rast_done (i.e. arriving while still in RAST) is ignored; the swap waits for the next vblank.
- SWAP: toggle fb_front; -> IDLE. Exactly one cycle.
- Start pulse rules:
  - Each start output is high for exactly one cycle per frame.
  - Never two start pulses in the same cycle.
- Done pulse rules:
  - A done pulse arriving in any state other than its own is ignored (no state change, no error).
- Overrun:
  - frame_tick while state != IDLE (sched_en=1) discards the tick.
  - drop_cnt increments, saturating at all-ones.
  - The current frame continues unaffected.
- A frame_tick in the SWAP cycle counts as a drop.
- sched_en=0:
  - Ticks are ignored and not counted.
  - A frame already in progress runs to completion, including the swap.
- Reset mid-frame: everything returns to reset values immediately; no start pulse is emitted during or after reset until the next qualifying tick.
- fb_front changes only in SWAP, so a buffer swap always occurs inside vertical blank.

Optional Feature:
- Macro FRAME_TIMEOUT_EN.
- Defined:
  - A 24-bit watchdog counts cycles spent in CLEAR/CLIP/RAST; it clears on each stage entry.
  - Reaching REFRESH_CNT*2 forces the FSM to IDLE without a swap.
  - Asserts output timeout_err (1 bit, sticky until reset).
- Not defined:
  - No watchdog and no timeout_err port; stages wait indefinitely for done.

Test Plan:
- REFRESH_CNT=100, sched_en=1, done pulses returned 5 cycles after each start, vblank at cycle 150 -> clr_start at cycle 100, clip_start at 106, rast_start at 112, fb_front 0->1 at cycle 152, busy low from 152.
- Hold rast_done off until cycle 250 with REFRESH_CNT=100 -> ticks at 199 and 299 dropped while busy, drop_cnt=2, no extra clr_start.
- rast_done and vblank_start in the same cycle -> no swap on that vblank; swap on the following vblank_start.
- sched_en=0 for 5 frame periods -> no start pulses, drop_cnt stays 0, fb_front unchanged. Re-enable -> clr_start one cycle after the next tick.
- Assert rst_n=0 while in CLIP, release -> state IDLE, fb_front=0, drop_cnt=0; a stray clip_done after reset has no effect.
- DROP_W=2, force 5 overruns -> drop_cnt saturates at 3.
